gray_bin_conv_arbiter: RTL and testbench

//   Shares one Gray->binary conversion datapath among NUM_REQ requesters.
//   A round-robin arbiter selects one requester per accepted transaction.
//   It converts the selected Gray word and registers the result in a
//   one-entry output stage, tagged with the requester ID.

---
 rtl/gray_bin_conv_arbiter_if.sv | 31 +++
 rtl/gray_bin_conv_arbiter.sv | 95 +++++++++
 tb/tb_gray_bin_conv_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/gray_bin_conv_arbiter_if.sv
// Purpose: request/response bundle for the shared Gray->binary converter.
// Latency: none (wires only).
// Backpressure: req_ready is returned per requester, rsp_ready is taken from the consumer.
interface gray_bin_conv_arbiter_if #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_gray;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_bin;
    logic [WIDTH-1:0]         rsp_gray;
    logic [ID_W-1:0]          rsp_id;
    logic                     busy;

    // Requesters and consumer side
    modport master (
        output req_valid, req_gray, rsp_ready,
        input  req_ready, rsp_valid, rsp_bin, rsp_gray, rsp_id, busy
    );

    // Converter side
    modport slave (
        input  req_valid, req_gray, rsp_ready,
        output req_ready, rsp_valid, rsp_bin, rsp_gray, rsp_id, busy
    );
endinterface

// File: rtl/gray_bin_conv_arbiter.sv
// Purpose: round-robin shares one Gray->binary converter among NUM_REQ requesters, result tagged with requester id.
// Latency: 1 cycle from accept to rsp_valid; 1 result per cycle while rsp_ready is high.
// Backpressure: one-entry output register; when full and rsp_ready is low, all req_ready drop and outputs hold.
module gray_bin_conv_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    gray_bin_conv_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;
    logic              can_accept;
    logic              accept;
    logic [WIDTH-1:0]  grant_gray;
    logic [WIDTH-1:0]  grant_bin;
    logic [WIDTH-1:0]  rsp_bin_q;
    logic [WIDTH-1:0]  rsp_gray_q;
    logic [ID_W-1:0]   rsp_id_q;
    int                idx;

    // Each binary bit is the XOR of that Gray bit and all bits above it,
    // written as a reduction so there is no bit-to-bit dependency chain.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    assign can_accept = (state == EMPTY) || bus.rsp_ready;

    // Round-robin search starting at ptr, wrapping at NUM_REQ-1
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    // One-hot accept strobe; held low during reset and while output is stalled
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && can_accept && grant_found) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    assign accept     = |(bus.req_valid & bus.req_ready);
    assign grant_gray = bus.req_gray[int'(grant_id)*WIDTH +: WIDTH];
    assign grant_bin  = gray2bin(grant_gray);

    // Output stage: load on accept (overwrites a draining result), else drain when consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            ptr        <= '0;
            rsp_bin_q  <= '0;
            rsp_gray_q <= '0;
            rsp_id_q   <= '0;
        end else if (accept) begin
            state      <= FULL;
            rsp_bin_q  <= grant_bin;
            rsp_gray_q <= grant_gray;
            rsp_id_q   <= grant_id;
            ptr        <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end else if (state == FULL && bus.rsp_ready) begin
            state <= EMPTY;
        end
    end

    assign bus.rsp_valid = (state == FULL);
    assign bus.busy      = (state == FULL);
    assign bus.rsp_bin   = rsp_bin_q;
    assign bus.rsp_gray  = rsp_gray_q;
    assign bus.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_gray_bin_conv_arbiter.sv
// Purpose: directed self-checking bench for gray_bin_conv_arbiter (4 requesters, 4-bit words).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: rsp_ready driven directly by the tasks.
module tb_gray_bin_conv_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    gray_bin_conv_arbiter_if #(.WIDTH(4), .NUM_REQ(4)) bus ();

    gray_bin_conv_arbiter #(.WIDTH(4), .NUM_REQ(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference conversion walking from the MSB downwards
    function automatic logic [3:0] ref_bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_gray  = 16'hFFFF;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready got=%0h exp=0", bus.req_ready); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        checks++; if ({bus.rsp_bin, bus.rsp_gray, bus.rsp_id} !== 10'h0) begin errors++; $display("FAIL reset_rsp_fields bin=%0h gray=%0h id=%0d exp=0", bus.rsp_bin, bus.rsp_gray, bus.rsp_id); end
        bus.req_valid = 4'h0;
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.req_valid = 4'b0001;
        bus.req_gray  = 16'h000D;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_req_ready got=%0b exp=0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b/%0b exp=1/1", bus.rsp_valid, bus.busy); end
        checks++; if (bus.rsp_bin !== 4'b1001) begin errors++; $display("FAIL single_bin got=%0b exp=1001", bus.rsp_bin); end
        checks++; if (bus.rsp_gray !== 4'b1101) begin errors++; $display("FAIL single_gray got=%0b exp=1101", bus.rsp_gray); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL single_id got=%0d exp=0", bus.rsp_id); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_id  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] exp_bin [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1111};
        pulse_reset();
        bus.req_gray  = {4'b1000, 4'b0110, 4'b0011, 4'b0001};
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_id[i]) begin errors++; $display("FAIL b2b_id[%0d] valid=%0b got=%0d exp=%0d", i, bus.rsp_valid, bus.rsp_id, exp_id[i]); end
            checks++; if (bus.rsp_bin !== exp_bin[exp_id[i]]) begin errors++; $display("FAIL b2b_bin[%0d] got=%0b exp=%0b", i, bus.rsp_bin, exp_bin[exp_id[i]]); end
        end
    endtask

    task automatic test_stall();
        // Continues from the back-to-back run: FULL with id 1, pointer at 2
        bus.rsp_ready = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL stall_req_ready got=%0b exp=0000", bus.req_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_bin !== 4'b0010 || bus.rsp_gray !== 4'b0011) begin errors++; $display("FAIL stall_hold[%0d] valid=%0b id=%0d bin=%0b gray=%0b exp=1/1/0010/0011", i, bus.rsp_valid, bus.rsp_id, bus.rsp_bin, bus.rsp_gray); end
            checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL stall_ready[%0d] got=%0b exp=0000", i, bus.req_ready); end
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL stall_release_ready got=%0b exp=0100", bus.req_ready); end
        tick();
        checks++; if (bus.rsp_id !== 2'd2 || bus.rsp_bin !== 4'b0100) begin errors++; $display("FAIL stall_resume_a id=%0d bin=%0b exp=2/0100", bus.rsp_id, bus.rsp_bin); end
        tick();
        bus.req_valid = 4'h0;
        checks++; if (bus.rsp_id !== 2'd3 || bus.rsp_bin !== 4'b1111) begin errors++; $display("FAIL stall_resume_b id=%0d bin=%0b exp=3/1111", bus.rsp_id, bus.rsp_bin); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%0b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_sparse();
        logic [1:0] exp_id [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        pulse_reset();
        bus.req_gray  = {4'b0100, 4'b0000, 4'b0111, 4'b0000};
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.req_ready[0] !== 1'b0 || bus.req_ready[2] !== 1'b0) begin errors++; $display("FAIL sparse_idle_ready[%0d] got=%0b exp=x0x0", i, bus.req_ready); end
            tick();
            checks++; if (bus.rsp_id !== exp_id[i] || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL sparse_id[%0d] got=%0d exp=%0d", i, bus.rsp_id, exp_id[i]); end
        end
        checks++; if (bus.rsp_bin !== 4'b0111) begin errors++; $display("FAIL sparse_bin got=%0b exp=0111", bus.rsp_bin); end
        bus.req_valid = 4'h0;
        tick();
    endtask

    task automatic test_sweep();
        logic [3:0] g;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0100;
        for (int v = 0; v < 16; v++) begin
            g = 4'(v);
            bus.req_gray = {4'h0, g, 4'h0, 4'h0};
            tick();
            checks++; if (bus.rsp_bin !== ref_bin(g) || bus.rsp_gray !== g || bus.rsp_id !== 2'd2) begin errors++; $display("FAIL sweep[%0d] bin=%0b exp=%0b gray=%0b id=%0d", v, bus.rsp_bin, ref_bin(g), bus.rsp_gray, bus.rsp_id); end
            if (g == 4'b1000) begin
                checks++; if (bus.rsp_bin !== 4'b1111) begin errors++; $display("FAIL sweep_1000 got=%0b exp=1111", bus.rsp_bin); end
            end
        end
        bus.req_valid = 4'h0;
        tick();
    endtask

    task automatic test_async_reset();
        bus.req_gray  = {4'h0, 4'h0, 4'h0, 4'b0110};
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b0;
        tick();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got=%0b exp=1", bus.rsp_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL areset_valid got=%0b/%0b exp=0/0", bus.rsp_valid, bus.busy); end
        checks++; if ({bus.rsp_bin, bus.rsp_gray, bus.rsp_id} !== 10'h0 || bus.req_ready !== 4'h0) begin errors++; $display("FAIL areset_clear bin=%0h gray=%0h id=%0d ready=%0b exp=0", bus.rsp_bin, bus.rsp_gray, bus.rsp_id, bus.req_ready); end
        bus.req_valid = 4'b0110;
        bus.req_gray  = {4'h0, 4'b0101, 4'b0010, 4'h0};
        bus.rsp_ready = 1'b1;
        #1 rst_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL areset_first_ready got=%0b exp=0010", bus.req_ready); end
        tick();
        checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_bin !== 4'b0011) begin errors++; $display("FAIL areset_first_grant id=%0d bin=%0b exp=1/0011", bus.rsp_id, bus.rsp_bin); end
        bus.req_valid = 4'h0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_sparse();
        test_sweep();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
